// File: rtl/ir_err_pkg.sv
// Shared types, default widths and the output saturation helper for the IR
// line-position error engine.
package ir_err_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int IR_W_DEF  = 12;
  localparam int ERR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Works on a 64-bit sign-extended value so any accumulator width up to 63
  // bits can share it. A value that already fits in err_w bits passes through
  // unchanged, which makes this a plain sign extension when ACC_W <= ERR_W.
  function automatic logic signed [63:0] sat_err(input logic signed [63:0] acc,
                                                 input int err_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (err_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (err_w - 1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/ir_err_seq.sv
// Sequencer for ir_err_accum: IDLE/ACCUM/DONE state machine and the shared
// adder's operand index.
module ir_err_seq
  import ir_err_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int IDX_W = $clog2(2 * N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] sel,
  output logic             sub,
  output logic             clr_acc,
  output logic             en_acc,
  output logic             done,
  output logic             busy,
  output logic             accum
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(2 * N_CH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (clr_acc)     idx <= '0;
      else if (en_acc) idx <= idx + IDX_W'(1);
    end
  end

  // done marks the final accumulate step so the result register lands while
  // the FSM sits in DONE.
  always_comb begin
    state_nxt = state;
    clr_acc   = 1'b0;
    en_acc    = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    accum     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clr_acc   = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        busy   = 1'b1;
        accum  = 1'b1;
        en_acc = 1'b1;
        if (idx == LAST) begin
          done      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy = 1'b1;
        if (start) begin
          clr_acc   = 1'b1;
          state_nxt = ACCUM;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sel = idx;
  assign sub = idx[0];

endmodule

// File: rtl/ir_err_accum.sv
// Line-position error engine: weighted left-minus-right sum of the IR pairs via
// one shared adder, saturated to ERR_W. Optional smoothing under ERR_FILT_EN.
module ir_err_accum
  import ir_err_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int IR_W       = IR_W_DEF,
`ifdef ERR_FILT_EN
  parameter int FILT_SHIFT = 2,
`endif
  parameter int ERR_W      = ERR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    IR_vld,
  input  logic [N_CH*IR_W-1:0]    IR_L,
  input  logic [N_CH*IR_W-1:0]    IR_R,
  input  logic                    ovr_clr,
  output logic signed [ERR_W-1:0] error,
  output logic                    err_vld,
  output logic                    busy,
  output logic                    ovr
);

  localparam int ACC_W = IR_W + N_CH + 1;
  localparam int IDX_W = $clog2(2 * N_CH);

  logic [IDX_W-1:0] sel;
  logic             sub;
  logic             clr_acc;
  logic             en_acc;
  logic             done;
  logic             accum;

  ir_err_seq #(.N_CH(N_CH), .IDX_W(IDX_W)) u_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (IR_vld),
    .sel     (sel),
    .sub     (sub),
    .clr_acc (clr_acc),
    .en_acc  (en_acc),
    .done    (done),
    .busy    (busy),
    .accum   (accum)
  );

  // ---- stage p0: snapshot, interleaved so sel indexes L_k at 2k, R_k at 2k+1
  logic [IR_W-1:0] snap_p0 [2*N_CH];

  always_ff @(posedge clk) begin
    if (clr_acc) begin
      for (int k = 0; k < N_CH; k++) begin
        snap_p0[2*k]   <= IR_L[k*IR_W +: IR_W];
        snap_p0[2*k+1] <= IR_R[k*IR_W +: IR_W];
      end
    end
  end

  // ---- stage p1: shared add/sub into the signed accumulator
  logic signed [ACC_W-1:0] term_p1;
  logic signed [ACC_W-1:0] acc_p1;
  logic signed [ACC_W-1:0] acc_nxt;

  assign term_p1 = $signed({{(ACC_W-IR_W){1'b0}}, snap_p0[sel]}) <<< (sel >> 1);
  assign acc_nxt = sub ? (acc_p1 - term_p1) : (acc_p1 + term_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          acc_p1 <= '0;
    else if (clr_acc) acc_p1 <= '0;
    else if (en_acc)  acc_p1 <= acc_nxt;
  end

  // ---- stage p2: saturate (and optionally smooth) into the held output
  logic signed [ERR_W-1:0] sat_p2;

  assign sat_p2 = ERR_W'(sat_err({{(64-ACC_W){acc_nxt[ACC_W-1]}}, acc_nxt}, ERR_W));

`ifdef ERR_FILT_EN
  logic signed [ERR_W:0] diff_p2;
  logic signed [ERR_W:0] step_p2;
  logic signed [ERR_W:0] filt_p2;
  logic                  first_upd;

  assign diff_p2 = $signed({sat_p2[ERR_W-1], sat_p2}) - $signed({error[ERR_W-1], error});
  assign step_p2 = diff_p2 >>> FILT_SHIFT;
  assign filt_p2 = $signed({error[ERR_W-1], error}) + step_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error     <= '0;
      err_vld   <= 1'b0;
      first_upd <= 1'b1;
    end else begin
      err_vld <= done;
      if (done) begin
        first_upd <= 1'b0;
        error     <= first_upd ? sat_p2 : ERR_W'(filt_p2);
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error   <= '0;
      err_vld <= 1'b0;
    end else begin
      err_vld <= done;
      if (done) error <= sat_p2;
    end
  end
`endif

  // A strobe arriving in DONE is a legal restart, so only ACCUM counts as overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   ovr <= 1'b0;
    else if (IR_vld && accum)  ovr <= 1'b1;
    else if (ovr_clr)          ovr <= 1'b0;
  end

endmodule

// File: tb/tb_ir_err_accum.sv
// Scoreboard bench for ir_err_accum: directed vectors push expected error and
// arrival cycle; a monitor pops and compares on every err_vld.
module tb_ir_err_accum;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               IR_vld = 1'b0;
  logic               ovr_clr = 1'b0;
  logic [47:0]        IR_L = '0;
  logic [47:0]        IR_R = '0;
  logic signed [15:0] error;
  logic               err_vld;
  logic               busy;
  logic               ovr;

  always #5 clk = ~clk;

  ir_err_accum dut (
    .clk     (clk),
    .rst     (rst),
    .IR_vld  (IR_vld),
    .IR_L    (IR_L),
    .IR_R    (IR_R),
    .ovr_clr (ovr_clr),
    .error   (error),
    .err_vld (err_vld),
    .busy    (busy),
    .ovr     (ovr)
  );

  typedef struct {
    int err;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   mdl_err = 0;
  bit   mdl_first = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Hand-computed raw sums go in; the smoothed build applies the IIR step.
  task automatic calc_expect(input int raw, output int e);
`ifdef ERR_FILT_EN
    if (mdl_first) begin
      mdl_first = 1'b0;
      mdl_err   = raw;
    end else begin
      mdl_err = mdl_err + ((raw - mdl_err) >>> 2);
    end
    e = mdl_err;
`else
    e = raw;
`endif
  endtask

  function automatic logic [47:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {a3[11:0], a2[11:0], a1[11:0], a0[11:0]};
  endfunction

  task automatic send(input logic [47:0] l, input logic [47:0] r, input int raw, input bit expect_out);
    exp_t e;
    @(posedge clk);
    #1;
    IR_L   = l;
    IR_R   = r;
    IR_vld = 1'b1;
    if (expect_out) begin
      calc_expect(raw, e.err);
      e.cyc = cyc + 9;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    IR_vld = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    chk(name, sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    mdl_first = 1'b1;
    mdl_err   = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && err_vld) begin
      if (sb.size() == 0) begin
        chk("spurious_err_vld", int'(error), 99999);
      end else begin
        mon_e = sb.pop_front();
        chk("error", int'(error), mon_e.err);
        chk("err_vld_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_error", int'(error), 0);
    chk("reset_err_vld", int'(err_vld), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ovr", int'(ovr), 0);

    // Single inner pair, then check busy during the run
    send(pk(100, 0, 0, 0), '0, 100, 1'b1);
    chk("busy_in_accum", int'(busy), 1);
    wait_drain("drain_inner");
    chk("idle_busy", int'(busy), 0);

    send('0, pk(0, 0, 0, 1000), -8000, 1'b1);
    wait_drain("drain_outer_right");
    send(pk(5, 6, 7, 8), pk(5, 6, 7, 8), 0, 1'b1);
    wait_drain("drain_symmetric");
    send(pk(1, 2, 3, 4), pk(4, 3, 2, 1), 23, 1'b1);
    wait_drain("drain_mixed");

    // Saturation both ways: 4095*15 = 61425 exceeds 16-bit range
    send(pk(4095, 4095, 4095, 4095), '0, 32767, 1'b1);
    wait_drain("drain_sat_pos");
    send('0, pk(4095, 4095, 4095, 4095), -32768, 1'b1);
    wait_drain("drain_sat_neg");

    // Reset in the middle of ACCUM discards the run
    send(pk(9, 9, 9, 9), '0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("midreset_error", int'(error), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_err_vld", int'(err_vld), 0);
    mdl_first = 1'b1;
    mdl_err   = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_error", int'(error), 0);

    // Overrun: second strobe 3 cycles later is dropped
    send(pk(100, 0, 0, 0), '0, 100, 1'b1);
    @(posedge clk);
    send(pk(0, 0, 0, 1000), '0, 0, 1'b0);
    chk("ovr_set", int'(ovr), 1);
    wait_drain("drain_overrun");
    chk("ovr_sticky", int'(ovr), 1);
    ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    ovr_clr = 1'b0;
    chk("ovr_cleared", int'(ovr), 0);

    // Set and clear in the same cycle: set wins
    send(pk(1, 0, 0, 0), '0, 1, 1'b1);
    @(posedge clk);
    #1;
    IR_vld  = 1'b1;
    ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    IR_vld  = 1'b0;
    ovr_clr = 1'b0;
    chk("ovr_set_wins", int'(ovr), 1);
    wait_drain("drain_set_wins");
    ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    ovr_clr = 1'b0;

    // Strobe during DONE is accepted: back-to-back results 9 cycles apart
    send(pk(100, 0, 0, 0), '0, 100, 1'b1);
    repeat (7) @(posedge clk);
    send(pk(0, 1, 0, 0), '0, 2, 1'b1);
    wait_drain("drain_done_accept");
    chk("done_accept_no_ovr", int'(ovr), 0);

`ifdef ERR_FILT_EN
    do_reset();
    send(pk(400, 0, 0, 0), '0, 400, 1'b1);
    wait_drain("drain_filt_first");
    chk("filt_first", int'(error), 400);
    send('0, '0, 0, 1'b1);
    wait_drain("drain_filt_step1");
    chk("filt_step1", int'(error), 300);
    send('0, '0, 0, 1'b1);
    wait_drain("drain_filt_step2");
    chk("filt_step2", int'(error), 225);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
